// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter: shares a 4-digit display between three sources with a minimum dwell time.
// Define SEG_ARB_ROTATE_EN for round-robin arbitration instead of fixed priority.
module seg_display_arbiter #(
  parameter int DWELL_TICKS = 500,
  parameter int CNT_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic [2:0]  req,
  input  logic [15:0] src0_bcd,
  input  logic [15:0] src1_bcd,
  input  logic [15:0] src2_bcd,
  output logic [3:0]  digit0,
  output logic [3:0]  digit1,
  output logic [3:0]  digit2,
  output logic [3:0]  digit3,
  output logic [2:0]  grant,
  output logic        dwell_lock
);
  typedef enum logic [1:0] {IDLE, LOCK, OPEN} state_t;
  state_t state, state_n;
  logic [2:0] grant_n, win;
  logic [15:0] digits, digits_n, own_bcd, win_bcd;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic done;
`ifdef SEG_ARB_ROTATE_EN
  logic [2:0] last, ref_o;
  assign ref_o = (state == OPEN) ? grant : last;
  // search starts just after the reference owner; the owner itself is checked last
  assign win = ref_o[0] ? (req[1] ? 3'b010 : req[2] ? 3'b100 : req[0] ? 3'b001 : 3'b000) :
               ref_o[1] ? (req[2] ? 3'b100 : req[0] ? 3'b001 : req[1] ? 3'b010 : 3'b000) :
                          (req[0] ? 3'b001 : req[1] ? 3'b010 : req[2] ? 3'b100 : 3'b000);
  always_ff @(posedge clk or posedge rst)
    if (rst) last <= 3'b100;
    else if (|grant) last <= grant;
`else
  assign win = req[0] ? 3'b001 : req[1] ? 3'b010 : req[2] ? 3'b100 : 3'b000;
`endif
  assign own_bcd = grant[0] ? src0_bcd : grant[1] ? src1_bcd : src2_bcd;
  assign win_bcd = win[0] ? src0_bcd : win[1] ? src1_bcd : src2_bcd;
  assign done = cnt == CNT_W'(DWELL_TICKS - 1);
  always_comb begin
    state_n = state;
    grant_n = grant;
    digits_n = digits;
    cnt_n = cnt;
    if (state == IDLE || state == OPEN) begin
      if (win == 3'b000) begin
        state_n = IDLE;
        grant_n = 3'b000;
        digits_n = '1;
      end else if (win != grant) begin
        state_n = LOCK;
        grant_n = win;
        digits_n = win_bcd;
        cnt_n = '0;
      end else digits_n = own_bcd;
    end else begin
      digits_n = |(req & grant) ? own_bcd : digits;
      if (tick) begin
        state_n = done ? OPEN : LOCK;
        cnt_n = done ? cnt : cnt + 1'b1;
      end
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      grant <= 3'b000;
      digits <= '1;
      cnt <= '0;
      dwell_lock <= 1'b0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      digits <= digits_n;
      cnt <= cnt_n;
      dwell_lock <= state_n == LOCK;
    end
  assign {digit3, digit2, digit1, digit0} = digits;
endmodule

// File: tb/tb_seg_display_arbiter.sv
// tb_seg_display_arbiter: directed vector table plus multi-cycle sequences for seg_display_arbiter.
module tb_seg_display_arbiter;
  logic clk = 1'b0, rst, tick;
  logic [2:0] req, grant;
  logic [15:0] s0, s1, s2;
  logic [3:0] d0, d1, d2, d3;
  logic lock;
  int tests = 0, fails = 0;

  seg_display_arbiter #(.DWELL_TICKS(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .tick(tick), .req(req),
    .src0_bcd(s0), .src1_bcd(s1), .src2_bcd(s2),
    .digit0(d0), .digit1(d1), .digit2(d2), .digit3(d3),
    .grant(grant), .dwell_lock(lock)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic t;
    logic [2:0] r;
    logic [15:0] a, b, c;
    logic [2:0] g;
    logic [15:0] d;
    logic l;
  } vec_t;
  vec_t v[20];

  task automatic check(input string nm, input logic [2:0] eg, input logic [15:0] ed, input logic el);
    tests++;
    if (grant !== eg || {d3, d2, d1, d0} !== ed || lock !== el) begin
      fails++;
      $display("FAIL %s: got grant=%b digits=%h lock=%b, expected grant=%b digits=%h lock=%b",
               nm, grant, {d3, d2, d1, d0}, lock, eg, ed, el);
    end
  endtask

  task automatic step(input logic t, input logic [2:0] r);
    @(negedge clk);
    tick = t;
    req = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = 3'b000;
    tick = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [2:0] rot_g(input int e);
`ifdef SEG_ARB_ROTATE_EN
    return e <= 40 ? 3'b001 : e <= 80 ? 3'b010 : e <= 120 ? 3'b100 : 3'b001;
`else
    return 3'b001;
`endif
  endfunction

  function automatic logic rot_l(input int e);
`ifdef SEG_ARB_ROTATE_EN
    return !(e == 40 || e == 80 || e == 120);
`else
    return e < 40;
`endif
  endfunction

  initial begin
    logic [2:0] g;
    rst = 1'b0;
    tick = 1'b0;
    req = 3'b000;
    s0 = '0;
    s1 = '0;
    s2 = '0;
    #3 rst = 1'b1;
    #1 check("reset_async", 3'b000, 16'hFFFF, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    v[0]  = '{1'b1, 3'b000, 16'h0000, 16'h0000, 16'h0000, 3'b000, 16'hFFFF, 1'b0};
    v[1]  = '{1'b1, 3'b100, 16'h0000, 16'h0000, 16'h1234, 3'b100, 16'h1234, 1'b1};
    v[2]  = '{1'b1, 3'b101, 16'h0099, 16'h0000, 16'h1234, 3'b100, 16'h1234, 1'b1};
    v[3]  = '{1'b0, 3'b101, 16'h0099, 16'h0000, 16'h5678, 3'b100, 16'h5678, 1'b1};
    v[4]  = '{1'b1, 3'b101, 16'h0099, 16'h0000, 16'h5678, 3'b100, 16'h5678, 1'b1};
    v[5]  = '{1'b1, 3'b001, 16'h0099, 16'h0000, 16'h1111, 3'b100, 16'h5678, 1'b1};
    v[6]  = '{1'b1, 3'b001, 16'h0099, 16'h0000, 16'h1111, 3'b100, 16'h5678, 1'b0};
    v[7]  = '{1'b0, 3'b001, 16'h0099, 16'h0000, 16'h1111, 3'b001, 16'h0099, 1'b1};
    v[8]  = '{1'b0, 3'b001, 16'h0042, 16'h0000, 16'h1111, 3'b001, 16'h0042, 1'b1};
    v[9]  = '{1'b1, 3'b001, 16'h0042, 16'h0000, 16'h1111, 3'b001, 16'h0042, 1'b1};
    v[10] = '{1'b1, 3'b001, 16'h0042, 16'h0000, 16'h1111, 3'b001, 16'h0042, 1'b1};
    v[11] = '{1'b1, 3'b001, 16'h0042, 16'h0000, 16'h1111, 3'b001, 16'h0042, 1'b1};
    v[12] = '{1'b1, 3'b001, 16'h0042, 16'h0000, 16'h1111, 3'b001, 16'h0042, 1'b0};
    v[13] = '{1'b1, 3'b001, 16'h0777, 16'h0000, 16'h1111, 3'b001, 16'h0777, 1'b0};
    v[14] = '{1'b0, 3'b010, 16'h0777, 16'h0321, 16'h1111, 3'b010, 16'h0321, 1'b1};
    v[15] = '{1'b1, 3'b000, 16'h0777, 16'h0ABC, 16'h1111, 3'b010, 16'h0321, 1'b1};
    v[16] = '{1'b1, 3'b000, 16'h0777, 16'h0ABC, 16'h1111, 3'b010, 16'h0321, 1'b1};
    v[17] = '{1'b1, 3'b000, 16'h0777, 16'h0ABC, 16'h1111, 3'b010, 16'h0321, 1'b1};
    v[18] = '{1'b1, 3'b000, 16'h0777, 16'h0ABC, 16'h1111, 3'b010, 16'h0321, 1'b0};
    v[19] = '{1'b0, 3'b000, 16'h0777, 16'h0ABC, 16'h1111, 3'b000, 16'hFFFF, 1'b0};
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      tick = v[i].t;
      req = v[i].r;
      s0 = v[i].a;
      s1 = v[i].b;
      s2 = v[i].c;
      @(posedge clk);
      #1 check($sformatf("vec%0d", i), v[i].g, v[i].d, v[i].l);
    end

    do_reset();
    s0 = 16'h1111;
    s1 = 16'h2222;
    s2 = 16'h3333;
    for (int e = 0; e <= 125; e++) begin
      step(e > 0 && e % 10 == 0, 3'b111);
      g = rot_g(e);
      check($sformatf("rotate_e%0d", e), g,
            g == 3'b001 ? 16'h1111 : g == 3'b010 ? 16'h2222 : 16'h3333, rot_l(e));
    end

    do_reset();
    s1 = 16'h0055;
    for (int e = 0; e <= 25; e++) step(e > 0 && e % 10 == 0, 3'b010);
    check("lock_before_rst", 3'b010, 16'h0055, 1'b1);
    #2 rst = 1'b1;
    #1 check("rst_mid_lock", 3'b000, 16'hFFFF, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    req = 3'b000;
    step(1'b0, 3'b000);
    check("idle_after_rst", 3'b000, 16'hFFFF, 1'b0);
    for (int e = 0; e <= 35; e++) begin
      step(e > 0 && e % 10 == 0, 3'b010);
      if (e == 0) check("regrant", 3'b010, 16'h0055, 1'b1);
    end
    check("lock_3_ticks", 3'b010, 16'h0055, 1'b1);
    for (int e = 36; e <= 40; e++) step(e % 10 == 0, 3'b010);
    check("open_4th_tick", 3'b010, 16'h0055, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/seg_display_arbiter.md
# seg_display_arbiter

Display-content arbiter that sits in front of the four-digit seven-segment multiplexing driver. It shares the single display between three requesting sources (for example speed readout, sensor distance, fault code) and enforces a minimum dwell time so the shown value cannot flicker between sources. It outputs four registered BCD digit nibbles that connect directly to the driver's digit inputs.

## Interface
- `DWELL_TICKS`, default 500: minimum number of `tick` pulses a newly granted source stays displayed; legal range is ≥1.
- `CNT_W`, default 10: width of the dwell counter; must satisfy 2^CNT_W > DWELL_TICKS.
- `clk`, in, 1: system clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `tick`, in, 1: single-cycle enable pulse (e.g. 1 kHz) used for dwell timing.
- `req`, in, 3: level request per source; bit 0 is source 0.
- `src0_bcd`, `src1_bcd`, `src2_bcd`, in, 16 each: source digits; [3:0] = digit0 (rightmost) … [15:12] = digit3.
- `digit0`, `digit1`, `digit2`, `digit3`, out, 4 each: registered digits to the driver.
- `grant`, out, 3: registered one-hot owner of the display; 0 when idle.
- `dwell_lock`, out, 1: high while in state LOCK.

## Operation
- States are IDLE, LOCK and OPEN.
- **IDLE**
  - `grant` = 0 and all digits = 4'hF (the driver blanks non-BCD codes).
  - If any `req` bit is high, select the winner, then go to LOCK.
- **Switch action** (used on every grant change):
  - `grant` ← winner.
  - Digits ← winner's `srcN_bcd`.
  - Dwell counter ← 0.
  - State ← LOCK.
- **LOCK**
  - `grant` is frozen. Requests from other sources are ignored; there is no preemption.
  - Each cycle, if `req[owner]` is high, digits ← owner's source value (live update). If it is low, digits hold their last value.
  - On `tick`, the counter increments.
  - When `tick` arrives with counter == DWELL_TICKS−1, go to OPEN with `grant` and digits unchanged.
- **OPEN**
  - Arbitrate every cycle.
    - If no `req` bit is high: go to IDLE, and blank the digits on the same edge.
    - If the winner ≠ owner: perform the switch action.
    - If the winner = owner: stay in OPEN, digits continue live update, counter idle.
  - The winner is taken from all `req` bits, including the owner's.
- **Fixed priority** (default): source 0 > source 1 > source 2.
- Digit nibbles pass through unmodified; values 10–15 are not checked or altered.

## Timing
- **Reset values:** state IDLE; `grant` = 3'b000; `digit0`–`digit3` = 4'hF; counter = 0; `dwell_lock` = 0. Reset acts immediately in any state, including mid-LOCK.
- **Request latency:** `req` sampled high at edge N (IDLE, or OPEN with a new winner) produces `grant` and digits valid after edge N, i.e. one cycle.
- **Live update latency:** one cycle from `srcN_bcd` to the digits.
- **Tick on the switch edge:** not counted. A `tick` coincident with the switch edge is dropped because the counter is cleared.
- **LOCK duration:** exactly DWELL_TICKS counted ticks.
- **Owner drops `req` during LOCK:** the display freezes; the decision is deferred until OPEN.
- **Request and drop on the same edge in OPEN:** arbitration uses the sampled `req` only.
- **`tick` in IDLE or OPEN:** ignored.
- **`dwell_lock`:** registered together with the state.

## Configuration
- Macro: `SEG_ARB_ROTATE_EN`.
- **Defined:** arbitration in OPEN is round-robin. The winner is the first requesting source after the current owner in cyclic order 0→1→2→0. The owner is selected only if it is the sole requester. From IDLE, the search starts after the last owner; after reset, the "last owner" is source 2, so source 0 is checked first.
- **Undefined:** fixed priority as described in Operation; the last-owner register is not built.

## Test plan
All scenarios use DWELL_TICKS = 4 and `tick` every 10 cycles.

- **Reset:** assert `rst` → digits 4'hF, `grant` = 0, `dwell_lock` = 0 immediately, without a clock edge.
- **Request from IDLE:** `req` = 3'b100 with `src2_bcd` = 16'h1234 → one cycle later `grant` = 3'b100, digits 4/3/2/1, `dwell_lock` = 1.
- **No preemption during dwell:** while src2 is in LOCK, raise `req[0]` with `src0_bcd` = 16'h0099.
  - `grant` stays 3'b100 for 4 ticks.
  - On the edge after the 4th tick, it goes OPEN. The next cycle, `grant` = 3'b001 and digits show 9/9/0/0.
- **Owner drops during LOCK:** src1 owns the display and drops `req` after 1 tick.
  - Digits hold their last value until the 4th tick, then blank to 4'hF on the next cycle (IDLE).
- **Rotation** (`SEG_ARB_ROTATE_EN` defined, all `req` = 3'b111) → grant sequence 001→010→100→001, each lasting exactly 4 ticks. Without the macro, `grant` stays 3'b001.
- **Reset during LOCK:** assert `rst` in the middle of LOCK, then release with `req` = 0 → state IDLE, counter restarts at 0 on the next grant.
